// File: rtl/core_done_barrier.sv
// Completion barrier over per-core cpu_done pulses; reports seen mask, first finisher and elapsed cycles.
// Optional ARMED-cycle timeout enabled by defining CORE_DONE_BARRIER_TIMEOUT_EN.
module core_done_barrier #(
  parameter int NUM_CORES   = 4,
  parameter int ELAPSED_W   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 busy,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [NUM_CORES-1:0] seen_mask,
  output logic [3:0]           first_core,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic                 timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

`ifdef CORE_DONE_BARRIER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic [1:0]           r_state;
  logic [NUM_CORES-1:0] r_mask;
  logic [NUM_CORES-1:0] r_seen;
  logic [3:0]           r_first;
  logic [ELAPSED_W-1:0] r_elapsed;
  logic                 r_timeout;

  logic [NUM_CORES-1:0] w_hit;
  logic [NUM_CORES-1:0] w_seen_nxt;
  logic                 w_complete;
  logic [ELAPSED_W-1:0] w_elapsed_nxt;
  logic                 w_tmo;
  logic [3:0]           w_hit_idx;
  logic                 w_found;

  assign w_hit         = core_done & r_mask & ~r_seen;
  assign w_seen_nxt    = r_seen | w_hit;
  assign w_complete    = (w_seen_nxt == r_mask);
  assign w_elapsed_nxt = (&r_elapsed) ? r_elapsed : r_elapsed + 1'b1;
  // Completion in the same cycle as the limit takes priority over timeout.
  assign w_tmo         = TMO_EN && (int'(w_elapsed_nxt) == TIMEOUT_CYC) && !w_complete;

  always_comb begin
    w_hit_idx = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (w_hit[i] && !w_found) begin
        w_hit_idx = 4'(i);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_seen    <= '0;
      r_first   <= '0;
      r_elapsed <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask    <= core_mask;
            r_seen    <= '0;
            r_first   <= '0;
            r_elapsed <= '0;
            r_timeout <= 1'b0;
            r_state   <= (core_mask == '0) ? S_REPORT : S_ARMED;
          end
        end
        S_ARMED: begin
          r_elapsed <= w_elapsed_nxt;
          r_seen    <= w_seen_nxt;
          if (r_seen == '0 && w_hit != '0) r_first <= w_hit_idx;
          if (w_complete) begin
            r_state <= S_REPORT;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_state   <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (done_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done_valid = (r_state == S_REPORT);
  assign seen_mask  = r_seen;
  assign first_core = r_first;
  assign elapsed    = r_elapsed;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_core_done_barrier.sv
// Randomized scoreboard bench for core_done_barrier; expectations come from per-core first-pulse times.
// Timeout scenarios are exercised when CORE_DONE_BARRIER_TIMEOUT_EN is defined.
module tb_core_done_barrier;

  localparam int NC  = 4;
  localparam int EW  = 5;
  localparam int TC  = 20;
  localparam int SL  = 64;
  localparam int PER = 10;

  logic          clk = 1'b0;
  logic          reset, start, done_ready;
  logic [NC-1:0] core_mask, core_done;
  logic          busy, done_valid, timeout;
  logic [NC-1:0] seen_mask;
  logic [3:0]    first_core;
  logic [EW-1:0] elapsed;

  core_done_barrier #(.NUM_CORES(NC), .ELAPSED_W(EW), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .reset(reset), .start(start), .core_mask(core_mask), .core_done(core_done),
    .busy(busy), .done_valid(done_valid), .done_ready(done_ready), .seen_mask(seen_mask),
    .first_core(first_core), .elapsed(elapsed), .timeout(timeout)
  );

  always #(PER/2) clk = ~clk;

  typedef struct {
    logic [NC-1:0] seen;
    logic [3:0]    first;
    logic [EW-1:0] el;
    logic          tmo;
    time           rise;
  } exp_t;

  exp_t          q[$];
  logic [NC-1:0] sched [SL];
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each masked core's first pulse time; barrier closes at the latest of them.
  function automatic exp_t model(input logic [NC-1:0] m, input time t_drive);
    exp_t e;
    int   fc[NC];
    int   tlim, c, best;
    bit   all_in;
`ifdef CORE_DONE_BARRIER_TIMEOUT_EN
    tlim = TC;
`else
    tlim = SL + 1;
`endif
    for (int j = 0; j < NC; j++) begin
      fc[j] = 0;
      for (int k = 0; k < SL; k++)
        if (m[j] && sched[k][j] && fc[j] == 0) fc[j] = k + 1;
    end
    all_in = 1'b1;
    c = 0;
    for (int j = 0; j < NC; j++) begin
      if (m[j]) begin
        if (fc[j] == 0 || fc[j] > tlim) all_in = 1'b0;
        else if (fc[j] > c) c = fc[j];
      end
    end
    e.seen = '0;
    e.tmo  = 1'b0;
    if (m == '0) c = 0;
    else if (all_in) e.seen = m;
    else begin
      c = tlim;
      e.tmo = 1'b1;
    end
    for (int j = 0; j < NC; j++)
      if (m[j] && fc[j] != 0 && fc[j] <= c) e.seen[j] = 1'b1;
    e.first = '0;
    best = SL + 10;
    for (int j = 0; j < NC; j++)
      if (e.seen[j] && fc[j] < best) begin
        best = fc[j];
        e.first = 4'(j);
      end
    e.el   = (c > (2**EW - 1)) ? EW'(2**EW - 1) : EW'(c);
    e.rise = t_drive + time'((c + 1) * PER);
    return e;
  endfunction

  // Monitor: pops on each rising done_valid and checks the held record every REPORT cycle.
  logic pv = 1'b0;
  bit   have = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (done_valid && !pv) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          have = 1'b0;
          $display("FAIL unexpected_result: got done_valid=1 expected no result at %0t", $time);
        end else begin
          cur  = q.pop_front();
          have = 1'b1;
          check("seen_mask", 64'(seen_mask), 64'(cur.seen));
          check("first_core", 64'(first_core), 64'(cur.first));
          check("elapsed", 64'(elapsed), 64'(cur.el));
          check("timeout", 64'(timeout), 64'(cur.tmo));
          check("valid_latency_time", 64'($time), 64'(cur.rise));
          check("busy_in_report", 64'(busy), 64'd1);
        end
      end else if (done_valid && have) begin
        check("held_record", 64'({seen_mask, first_core, elapsed, timeout}),
              64'({cur.seen, cur.first, cur.el, cur.tmo}));
      end
      pv = done_valid;
    end
  end

  task automatic clear_sched();
    for (int k = 0; k < SL; k++) sched[k] = '0;
  endtask

  task automatic pulse(input int core, input int cyc);
    sched[cyc-1][core] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; core_done = '0; done_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input logic [NC-1:0] m, input int hold);
    bit got;
    int n;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      core_done = NC'($urandom);
      @(negedge clk);
    end
    start      = 1'b1;
    core_mask  = m;
    core_done  = NC'($urandom);
    done_ready = 1'($urandom);
    q.push_back(model(m, $time));
    got = 1'b0;
    for (int k = 0; k < SL; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_valid) begin
        got = 1'b1;
        break;
      end
      core_done  = sched[k];
      core_mask  = NC'($urandom);
      done_ready = 1'($urandom);
    end
    if (!got) begin
      @(negedge clk);
      got = done_valid;
    end
    if (!got) begin
      check("result_within_budget", 64'd0, 64'd1);
      void'(q.pop_front());
      do_reset();
      return;
    end
    n = 0;
    while (done_valid && n < 200) begin
      core_done  = NC'($urandom);
      start      = 1'($urandom);
      done_ready = (n < hold) ? 1'b0 : ($urandom_range(0, 2) == 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("idle_after_ack", 64'({busy, done_valid}), 64'd0);
  endtask

  initial begin
    bit            bad;
    logic [NC-1:0] m;
    core_mask = '0;
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("reset_outputs", 64'({busy, done_valid, seen_mask, first_core, elapsed, timeout}), 64'd0);
    reset = 1'b0;

    clear_sched(); pulse(0, 5); pulse(1, 10);
    run(4'b0011, 0);
    clear_sched(); pulse(3, 2); pulse(1, 2); pulse(0, 4); pulse(2, 6);
    run(4'b1111, 0);
    clear_sched(); pulse(1, 1); pulse(0, 2); pulse(0, 4); pulse(1, 5); pulse(2, 6);
    run(4'b0101, 0);
    clear_sched(); pulse(2, 3); pulse(1, 8);
    run(4'b0110, 7);
    clear_sched(); pulse(0, 1);
    run(4'b0000, 3);
    clear_sched(); pulse(0, 40); pulse(1, 3);
    run(4'b0011, 0);

    // Reset mid-run drops the barrier without a result.
    @(negedge clk);
    start = 1'b1; core_mask = 4'b0011; core_done = '0;
    @(negedge clk);
    start = 1'b0; core_done = 4'b0001;
    @(negedge clk);
    core_done = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_armed", 64'({busy, done_valid, seen_mask, first_core, elapsed, timeout}), 64'd0);
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      core_done = (k % 2 == 0) ? 4'b0010 : 4'b0001;
      @(negedge clk);
      if (done_valid || busy) bad = 1'b1;
    end
    core_done = '0;
    check("no_result_after_reset", 64'(bad), 64'd0);

`ifdef CORE_DONE_BARRIER_TIMEOUT_EN
    clear_sched(); pulse(0, 3);
    run(4'b0011, 0);
    clear_sched(); pulse(0, 3); pulse(1, 20);
    run(4'b0011, 0);
    clear_sched(); pulse(1, 21);
    run(4'b0010, 0);
`endif

    for (int r = 0; r < 40; r++) begin
      clear_sched();
      m = NC'($urandom);
      for (int j = 0; j < NC; j++) begin
`ifdef CORE_DONE_BARRIER_TIMEOUT_EN
        if (m[j] && $urandom_range(0, 3) != 0) pulse(j, $urandom_range(1, 30));
`else
        if (m[j]) pulse(j, $urandom_range(1, 45));
`endif
      end
      for (int x = 0; x < 6; x++) sched[$urandom_range(0, SL-1)][$urandom_range(0, NC-1)] = 1'b1;
      run(m, $urandom_range(0, 3));
    end

    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
